// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Single-master memory controller between the core's instruction-fetch (IF)
// and load/store (LS) ports and two targets: synchronous RAM and the IO block.
// One transaction is in flight at a time. IF and LS share the port under
// round-robin priority. The address decodes to RAM, IO or unmapped. Every
// transaction ends with a one-cycle completion pulse to its owner. An IO
// timeout stops a stuck peripheral from hanging the core.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   if_req_i/if_addr_i          IF read request and address
//   if_gnt_o                    IF accepted (combinational, IDLE only)
//   if_rvalid_o/if_err_o        IF completion pulse and error qualifier
//   if_rdata_o                  IF read data, valid with if_rvalid_o
//   ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_be_i   LS request fields
//   ls_gnt_o/ls_rvalid_o/ls_err_o/ls_rdata_o        LS response, as for IF
//   ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o        RAM strobe and fields
//   ram_rdata_i                 RAM read data, valid the cycle after ram_en_o
//   io_req_o/io_we_o/io_be_o/io_addr_o/io_wdata_o   IO request (level) and fields
//   io_ack_i/io_rdata_i         IO completion; read data valid with the ack
module mem_bus_arbiter #(
  parameter int IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  input  logic [3:0]  ls_be_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [27:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic        io_req_o,
  output logic        io_we_o,
  output logic [3:0]  io_be_o,
  output logic [15:0] io_addr_o,
  output logic [31:0] io_wdata_o,
  input  logic        io_ack_i,
  input  logic [31:0] io_rdata_i
);

  localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(IO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAM  = 2'd1,
    S_IO   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_last_ls;   // last grant went to LS (reset: IF)
  logic          r_owner_ls;  // owner of the transaction in flight
  logic          r_we;
  logic [CW-1:0] r_cnt;
  logic          r_rd_ram;    // RESP of a RAM read: return ram_rdata_i directly
  logic [31:0]   r_rdata;
  logic          r_if_rvalid;
  logic          r_if_err;
  logic          r_ls_rvalid;
  logic          r_ls_err;
  logic          r_ram_en;
  logic [3:0]    r_ram_we;
  logic [27:0]   r_ram_addr;
  logic [31:0]   r_ram_wdata;
  logic          r_io_req;
  logic          r_io_we;
  logic [3:0]    r_io_be;
  logic [15:0]   r_io_addr;
  logic [31:0]   r_io_wdata;

  logic          w_idle;
  logic          w_gnt_if;
  logic          w_gnt_ls;
  logic          w_any_gnt;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_we;
  logic [3:0]    w_be;
  logic          w_is_ram;
  logic          w_is_io;
  logic          w_resp_data_sel;
  logic [31:0]   w_resp_data;

  // Round-robin grant and selection of the winning requester's fields
  always_comb begin
    // Gated by rst_n so that no grant is seen while reset is held
    w_idle    = (r_state == S_IDLE) && rst_n;
    // On a tie, grant the requester that was not granted last
    w_gnt_ls  = w_idle && ls_req_i && (!if_req_i || !r_last_ls);
    w_gnt_if  = w_idle && if_req_i && !w_gnt_ls;
    w_any_gnt = w_gnt_if || w_gnt_ls;
    if (w_gnt_ls) begin
      w_addr  = ls_addr_i;
      w_we    = ls_we_i;
      w_be    = ls_be_i;
      w_wdata = ls_wdata_i;
    end else begin
      // IF fetches are always full-word reads
      w_addr  = if_addr_i;
      w_we    = 1'b0;
      w_be    = 4'hF;
      w_wdata = 32'h0000_0000;
    end
    w_is_ram        = (w_addr[31:28] == 4'h0);
    w_is_io         = (w_addr[31:16] == 16'hF000);
    w_resp_data_sel = r_rd_ram;
    w_resp_data     = w_resp_data_sel ? ram_rdata_i : r_rdata;
  end

  assign if_gnt_o    = w_gnt_if;
  assign ls_gnt_o    = w_gnt_ls;
  assign if_rvalid_o = r_if_rvalid;
  assign if_err_o    = r_if_err;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_err_o    = r_ls_err;
  // Read data shows only on the owner's rvalid cycle; otherwise it stays zero
  assign if_rdata_o  = r_if_rvalid ? w_resp_data : 32'h0000_0000;
  assign ls_rdata_o  = r_ls_rvalid ? w_resp_data : 32'h0000_0000;
  assign ram_en_o    = r_ram_en;
  assign ram_we_o    = r_ram_we;
  assign ram_addr_o  = r_ram_addr;
  assign ram_wdata_o = r_ram_wdata;
  assign io_req_o    = r_io_req;
  assign io_we_o     = r_io_we;
  assign io_be_o     = r_io_be;
  assign io_addr_o   = r_io_addr;
  assign io_wdata_o  = r_io_wdata;

  // Transaction FSM with registered target strobes and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_ls   <= 1'b0;
      r_owner_ls  <= 1'b0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_rd_ram    <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 4'h0;
      r_ram_addr  <= 28'h000_0000;
      r_ram_wdata <= 32'h0000_0000;
      r_io_req    <= 1'b0;
      r_io_we     <= 1'b0;
      r_io_be     <= 4'h0;
      r_io_addr   <= 16'h0000;
      r_io_wdata  <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_gnt) begin
            r_owner_ls <= w_gnt_ls;
            r_last_ls  <= w_gnt_ls;
            r_we       <= w_we;
            if (w_is_ram) begin
              r_state     <= S_RAM;
              r_ram_en    <= 1'b1;
              r_ram_we    <= w_we ? w_be : 4'h0;
              r_ram_addr  <= w_addr[27:0];
              r_ram_wdata <= w_wdata;
            end else if (w_is_io) begin
              r_state    <= S_IO;
              r_io_req   <= 1'b1;
              r_io_we    <= w_we;
              r_io_be    <= w_be;
              r_io_addr  <= w_addr[15:0];
              r_io_wdata <= w_wdata;
              r_cnt      <= '0;
            end else begin
              // Unmapped: answer at once with an error and touch no target
              r_state     <= S_RESP;
              r_if_rvalid <= w_gnt_if;
              r_if_err    <= w_gnt_if;
              r_ls_rvalid <= w_gnt_ls;
              r_ls_err    <= w_gnt_ls;
              r_rd_ram    <= 1'b0;
              r_rdata     <= 32'h0000_0000;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RAM: begin
          r_state     <= S_RESP;
          r_ram_en    <= 1'b0;
          r_ram_we    <= 4'h0;
          r_ram_addr  <= 28'h000_0000;
          r_ram_wdata <= 32'h0000_0000;
          r_if_rvalid <= !r_owner_ls;
          r_ls_rvalid <= r_owner_ls;
          r_if_err    <= 1'b0;
          r_ls_err    <= 1'b0;
          // RAM data arrives during RESP and is forwarded straight through
          r_rd_ram    <= !r_we;
          r_rdata     <= 32'h0000_0000;
        end
        S_IO: begin
          // The ack takes priority over a timeout that falls on the same cycle
          if (io_ack_i || (r_cnt == CNT_LAST)) begin
            r_state     <= S_RESP;
            r_io_req    <= 1'b0;
            r_io_we     <= 1'b0;
            r_io_be     <= 4'h0;
            r_io_addr   <= 16'h0000;
            r_io_wdata  <= 32'h0000_0000;
            r_if_rvalid <= !r_owner_ls;
            r_ls_rvalid <= r_owner_ls;
            r_if_err    <= !r_owner_ls && !io_ack_i;
            r_ls_err    <= r_owner_ls && !io_ack_i;
            r_rd_ram    <= 1'b0;
            r_rdata     <= (io_ack_i && !r_we) ? io_rdata_i : 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_if_rvalid <= 1'b0;
          r_if_err    <= 1'b0;
          r_ls_rvalid <= 1'b0;
          r_ls_err    <= 1'b0;
          r_rd_ram    <= 1'b0;
          r_rdata     <= 32'h0000_0000;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
